// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite response codes, channel FSM state types and the byte-merge helper
// used by the register-file responder.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_W,
        W_WAIT_AW,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Lanes whose strobe bit is clear keep their current contents.
    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int unsigned n = 0; n < 4; n++) begin
            if (strb[n]) begin
                res[8*n +: 8] = wdata[8*n +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axilite_addr_decode.sv
// Combinational address decode for the register window: byte address -> {hit, register index}.
module axilite_addr_decode #(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000
) (
    input  logic [ADDR_W-1:0]           addr,
    output logic                        hit,
    output logic [$clog2(NUM_REGS)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_REGS * 4);

    logic [ADDR_W-1:0] off;

    always_comb begin
        off = addr - BASE_ADDR;
        hit = (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
        idx = off[IDX_W+1:2];
    end

    // Byte-lane bits and bits above the window only matter to the hit check.
    logic unused_off_bits;
    assign unused_off_bits = ^{off[ADDR_W-1:IDX_W+2], off[1:0]};

endmodule

// File: rtl/axilite_slave_regfile.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers at BASE_ADDR,
// with independent write and read channel FSMs and SLVERR on out-of-window accesses.
module axilite_slave_regfile
    import axilite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    wr_state_t         wr_state;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    rd_state_t         rd_state;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              wr_commit;
    logic [ADDR_W-1:0] wr_addr_eff;
    logic [DATA_W-1:0] wr_data_eff;
    logic [STRB_W-1:0] wr_strb_eff;
    logic              wr_hit;
    logic [IDX_W-1:0]  wr_idx;
    logic              rd_hit;
    logic [IDX_W-1:0]  rd_idx;

    logic unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // The completing handshake may carry either half live on the bus;
    // the other half comes from whatever was latched earlier.
    always_comb begin
        aw_hs       = s_axi_awvalid && s_axi_awready;
        w_hs        = s_axi_wvalid  && s_axi_wready;
        ar_hs       = s_axi_arvalid && s_axi_arready;
        wr_addr_eff = (wr_state == W_WAIT_W)  ? aw_addr_q : s_axi_awaddr;
        wr_data_eff = (wr_state == W_WAIT_AW) ? w_data_q  : s_axi_wdata;
        wr_strb_eff = (wr_state == W_WAIT_AW) ? w_strb_q  : s_axi_wstrb;
        wr_commit   = ((wr_state == W_IDLE)    && aw_hs && w_hs) ||
                      ((wr_state == W_WAIT_W)  && w_hs)          ||
                      ((wr_state == W_WAIT_AW) && aw_hs);
    end

    axilite_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_wr_decode (
        .addr (wr_addr_eff),
        .hit  (wr_hit),
        .idx  (wr_idx)
    );

    axilite_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_rd_decode (
        .addr (s_axi_araddr),
        .hit  (rd_hit),
        .idx  (rd_idx)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state      <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_commit && wr_hit) begin
                regs[wr_idx] <= apply_strb(regs[wr_idx], wr_data_eff, wr_strb_eff);
            end

            if (wr_commit) begin
                wr_state      <= W_RESP;
                s_axi_awready <= 1'b0;
                s_axi_wready  <= 1'b0;
                s_axi_bvalid  <= 1'b1;
                s_axi_bresp   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            aw_addr_q     <= s_axi_awaddr;
                            s_axi_awready <= 1'b0;
                            wr_state      <= W_WAIT_W;
                        end else if (w_hs) begin
                            w_data_q     <= s_axi_wdata;
                            w_strb_q     <= s_axi_wstrb;
                            s_axi_wready <= 1'b0;
                            wr_state     <= W_WAIT_AW;
                        end
                    end
                    W_WAIT_W, W_WAIT_AW: begin
                        wr_state <= wr_state;
                    end
                    W_RESP: begin
                        if (s_axi_bready) begin
                            s_axi_bvalid  <= 1'b0;
                            s_axi_awready <= 1'b1;
                            s_axi_wready  <= 1'b1;
                            wr_state      <= W_IDLE;
                        end
                    end
                    default: begin
                        wr_state <= W_IDLE;
                    end
                endcase
            end
        end
    end

    // Capture reads the register array before this edge's write lands,
    // so a same-edge read of the written register returns the old value.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state      <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_rdata   <= rd_hit ? regs[rd_idx] : '0;
                        s_axi_rresp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        rd_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state      <= R_IDLE;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// Self-checking bench for axilite_slave_regfile: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then concurrent randomized traffic.
module tb_axilite_slave_regfile;
    import axilite_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h1000_0000;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    axilite_slave_regfile #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
    endfunction

    // Transaction-level reference: register array plus outstanding-transaction flags.
    logic [31:0] m_regs [NUM_REGS];
    bit          m_aw_pend, m_w_pend, m_b_pend, m_r_pend, started;
    logic [31:0] m_aw_addr, m_w_data, m_rdata;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_bresp, m_rresp;

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(NUM_REGS * 4));
    endfunction

    always @(negedge aclk) begin
        bit exp_awr, exp_wr, exp_arr, aw_hs, w_hs, ar_hs;
        int k;
        exp_awr = !m_aw_pend && !m_b_pend;
        exp_wr  = !m_w_pend  && !m_b_pend;
        exp_arr = !m_r_pend;
        if (started) begin
            check("awready", 32'(s_axi_awready), 32'(exp_awr));
            check("wready",  32'(s_axi_wready),  32'(exp_wr));
            check("arready", 32'(s_axi_arready), 32'(exp_arr));
            check("bvalid",  32'(s_axi_bvalid),  32'(m_b_pend));
            check("rvalid",  32'(s_axi_rvalid),  32'(m_r_pend));
            if (m_b_pend) check("bresp", 32'(s_axi_bresp), 32'(m_bresp));
            if (m_r_pend) begin
                check("rdata", s_axi_rdata, m_rdata);
                check("rresp", 32'(s_axi_rresp), 32'(m_rresp));
            end
        end
        if (!aresetn) begin
            started = 1;
            m_aw_pend = 0; m_w_pend = 0; m_b_pend = 0; m_r_pend = 0;
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        end else if (started) begin
            aw_hs = s_axi_awvalid && exp_awr;
            w_hs  = s_axi_wvalid  && exp_wr;
            ar_hs = s_axi_arvalid && exp_arr;
            if (m_b_pend && s_axi_bready) m_b_pend = 0;
            if (m_r_pend && s_axi_rready) begin
                m_r_pend = 0;
            end else if (ar_hs) begin
                m_r_pend = 1;
                if (in_window(s_axi_araddr)) begin
                    m_rdata = m_regs[int'((s_axi_araddr - BASE) >> 2)];
                    m_rresp = RESP_OKAY;
                end else begin
                    m_rdata = '0;
                    m_rresp = RESP_SLVERR;
                end
            end
            if (aw_hs) begin m_aw_pend = 1; m_aw_addr = s_axi_awaddr; end
            if (w_hs)  begin m_w_pend = 1; m_w_data = s_axi_wdata; m_w_strb = s_axi_wstrb; end
            if (m_aw_pend && m_w_pend) begin
                if (in_window(m_aw_addr)) begin
                    k = int'((m_aw_addr - BASE) >> 2);
                    for (int b = 0; b < 4; b++)
                        if (m_w_strb[b]) m_regs[k][8*b +: 8] = m_w_data[8*b +: 8];
                    m_bresp = RESP_OKAY;
                end else begin
                    m_bresp = RESP_SLVERR;
                end
                m_b_pend = 1; m_aw_pend = 0; m_w_pend = 0;
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input int dly);
        bit ok = 0;
        repeat (dly) begin @(posedge aclk); #1; end
        s_axi_awaddr = a; s_axi_awprot = 3'($urandom); s_axi_awvalid = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            if (s_axi_awready) begin ok = 1; break; end
        end
        if (!ok) timeout("aw_handshake");
        @(posedge aclk); #1;
        s_axi_awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit ok = 0;
        repeat (dly) begin @(posedge aclk); #1; end
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            if (s_axi_wready) begin ok = 1; break; end
        end
        if (!ok) timeout("w_handshake");
        @(posedge aclk); #1;
        s_axi_wvalid = 0;
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_stall,
                             output logic [1:0] resp);
        bit ok = 0;
        s_axi_bready = (b_stall == 0);
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        repeat (b_stall) begin @(posedge aclk); #1; end
        s_axi_bready = 1;
        resp = 2'bxx;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            if (s_axi_bvalid) begin ok = 1; resp = s_axi_bresp; break; end
        end
        if (!ok) timeout("b_handshake");
        @(posedge aclk); #1;
    endtask

    task automatic read_txn(input logic [31:0] a, input int ar_dly, input int r_stall,
                            output logic [31:0] d, output logic [1:0] resp);
        bit ok = 0;
        s_axi_rready = (r_stall == 0);
        repeat (ar_dly) begin @(posedge aclk); #1; end
        s_axi_araddr = a; s_axi_arprot = 3'($urandom); s_axi_arvalid = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            if (s_axi_arready) begin ok = 1; break; end
        end
        if (!ok) timeout("ar_handshake");
        @(posedge aclk); #1;
        s_axi_arvalid = 0;
        repeat (r_stall) begin @(posedge aclk); #1; end
        s_axi_rready = 1;
        ok = 0; d = 'x; resp = 2'bxx;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            if (s_axi_rvalid) begin ok = 1; d = s_axi_rdata; resp = s_axi_rresp; break; end
        end
        if (!ok) timeout("r_handshake");
        @(posedge aclk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int k = int'($urandom_range(0, 9));
        if (k < 8)  return BASE + 32'($urandom_range(0, NUM_REGS * 4 - 1));
        if (k == 8) return BASE + 32'(NUM_REGS * 4) + 32'($urandom_range(0, 255));
        return BASE - 32'($urandom_range(1, 64));
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        aresetn = 0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 1;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 0; s_axi_rready = 1;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;

        // Basic strobed writes from reset
        write_txn(32'h1000_0000, 32'h0002_3124, 4'b1111, 0, 0, 0, r); check("t1_bresp0", 32'(r), 32'(RESP_OKAY));
        write_txn(32'h1000_0004, 32'hF0F0_F0F0, 4'b1110, 0, 0, 0, r); check("t1_bresp1", 32'(r), 32'(RESP_OKAY));
        write_txn(32'h1000_0008, 32'hAAAA_AAAA, 4'b0101, 0, 0, 0, r); check("t1_bresp2", 32'(r), 32'(RESP_OKAY));
        read_txn(32'h1000_0000, 0, 0, d, r); check("t1_rdata0", d, 32'h0002_3124); check("t1_rresp0", 32'(r), 32'(RESP_OKAY));
        read_txn(32'h1000_0004, 0, 0, d, r); check("t1_rdata1", d, 32'hF0F0_F000);
        read_txn(32'h1000_0008, 0, 0, d, r); check("t1_rdata2", d, 32'h00AA_00AA);

        // W three cycles ahead of AW
        s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
        @(negedge aclk); check("t2_wready_c0", 32'(s_axi_wready), 32'd1);
        @(posedge aclk); #1 s_axi_wvalid = 0;
        @(negedge aclk); check("t2_wready_c1", 32'(s_axi_wready), 32'd0);
        check("t2_awready_c1", 32'(s_axi_awready), 32'd1);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        s_axi_awaddr = 32'h1000_0004; s_axi_awvalid = 1;
        @(negedge aclk); check("t2_bvalid_c3", 32'(s_axi_bvalid), 32'd0);
        @(posedge aclk); #1 s_axi_awvalid = 0;
        @(negedge aclk); check("t2_bvalid_c4", 32'(s_axi_bvalid), 32'd1);
        @(posedge aclk); #1;
        read_txn(32'h1000_0004, 0, 0, d, r); check("t2_rdata", d, 32'h1234_5678);

        // Response back-pressure on both channels
        write_txn(32'h1000_000C, 32'hCAFE_BABE, 4'hF, 0, 0, 5, r); check("t3_bresp", 32'(r), 32'(RESP_OKAY));
        read_txn(32'h1000_000C, 0, 5, d, r); check("t3_rdata", d, 32'hCAFE_BABE);

        // Out-of-window accesses
        write_txn(32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r); check("t4_bresp_hi", 32'(r), 32'(RESP_SLVERR));
        write_txn(32'h0FFF_FFFC, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, r); check("t4_bresp_lo", 32'(r), 32'(RESP_SLVERR));
        read_txn(32'h1000_0040, 0, 0, d, r); check("t4_rdata", d, 32'h0); check("t4_rresp", 32'(r), 32'(RESP_SLVERR));
        read_txn(32'h1000_0000, 0, 0, d, r); check("t4_reg0_kept", d, 32'h0002_3124);
        read_txn(32'h1000_003C, 0, 0, d, r); check("t4_reg15_kept", d, 32'h0);

        // Read capture on the same edge as the write commit
        write_txn(32'h1000_0004, 32'h1111_1111, 4'hF, 0, 0, 0, r);
        s_axi_awaddr = 32'h1000_0004; s_axi_awvalid = 1;
        @(posedge aclk); #1 s_axi_awvalid = 0;
        s_axi_wdata = 32'h2222_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
        s_axi_araddr = 32'h1000_0004; s_axi_arvalid = 1;
        @(posedge aclk); #1 s_axi_wvalid = 0; s_axi_arvalid = 0;
        @(negedge aclk);
        check("t5_rdata_old", s_axi_rdata, 32'h1111_1111);
        check("t5_bvalid", 32'(s_axi_bvalid), 32'd1);
        @(posedge aclk); #1;
        read_txn(32'h1000_0004, 0, 0, d, r); check("t5_rdata_new", d, 32'h2222_2222);

        // Reset while both channels are mid-transaction
        s_axi_rready = 0;
        s_axi_awaddr = 32'h1000_0008; s_axi_awvalid = 1;
        s_axi_araddr = 32'h1000_0000; s_axi_arvalid = 1;
        @(posedge aclk); #1 s_axi_awvalid = 0; s_axi_arvalid = 0;
        @(negedge aclk); check("t6_rvalid_pre", 32'(s_axi_rvalid), 32'd1);
        check("t6_awready_pre", 32'(s_axi_awready), 32'd0);
        @(posedge aclk); #1 aresetn = 0;
        @(posedge aclk); #1 aresetn = 1; s_axi_rready = 1;
        @(negedge aclk);
        check("t6_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("t6_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("t6_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        @(posedge aclk); #1;
        read_txn(32'h1000_0000, 0, 0, d, r); check("t6_reg0", d, 32'h0);
        read_txn(32'h1000_0004, 0, 0, d, r); check("t6_reg1", d, 32'h0);

        // Concurrent randomized traffic on both channels
        fork
            begin
                logic [1:0] wr;
                for (int i = 0; i < 120; i++)
                    write_txn(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, wr);
            end
            begin
                logic [31:0] rd;
                logic [1:0]  rr;
                for (int i = 0; i < 120; i++)
                    read_txn(rand_addr(), int'($urandom_range(0, 3)),
                             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, rd, rr);
            end
        join

        repeat (2) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
